// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   dmem_state_t       : responder FSM states
//   LAT_W              : width of the latency down-counter (covers LATENCY 1..15)
//   BYTE_W             : bits per byte lane
//   DMEM_DEPTH_DEFAULT : default number of words in the array
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no transaction in flight
        WAIT = 2'd1,   // latency counter running
        RESP = 2'd2    // response presented on rsp_*
    } dmem_state_t;

    localparam int LAT_W              = 4;
    localparam int BYTE_W             = 8;
    localparam int DMEM_DEPTH_DEFAULT = 1024;

endpackage : dmem_pkg

// File: rtl/dmem_sram_bank.sv
// -----------------------------------------------------------------------------
// dmem_sram_bank
// Synchronous byte-enabled word array with one write port and one registered
// read port. Kept behaviourally simple so it can be replaced by a vendor macro.
//   clk   : clock, rising edge
//   we    : write enable
//   widx  : write word index
//   wdata : write data (lane positioned)
//   be    : per-byte write enables
//   re    : read enable; rdata is updated on the edge where re=1
//   ridx  : read word index
//   rdata : registered read data, holds its value while re=0
// -----------------------------------------------------------------------------
module dmem_sram_bank
    import dmem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = DMEM_DEPTH_DEFAULT,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int MASK_SIZE  = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_SIZE-1:0]  be,
    input  logic                  re,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset; clearing a RAM
    // takes DEPTH cycles or a huge reset fan-out, and macros cannot do it.
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order of statements or processes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_SIZE; i++) begin
                if (be[i]) begin
                    mem_q[widx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[ridx];
        end
    end

    assign rdata = rdata_q;

endmodule : dmem_sram_bank

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Data-memory responder for the LSU dmem side. Accepts one word-addressed,
// byte-masked request at a time, commits stores on the accepting edge and
// returns the full aligned word LATENCY cycles after accept.
//   clk        : clock, rising edge
//   arst_n     : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : request can be accepted this cycle (combinational on rsp_ready)
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address; word index = req_addr[ADDR_WIDTH-1:2]
//   req_wdata  : lane-positioned store data
//   req_mask   : byte enables for stores
//   rsp_valid  : response present
//   rsp_ready  : requester consumes the response
//   rsp_rdata  : full word for in-range loads, otherwise 0
//   rsp_err    : access was out of range
// -----------------------------------------------------------------------------
module dmem_resp
    import dmem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DEPTH      = DMEM_DEPTH_DEFAULT,
    parameter  int LATENCY    = 1,
    localparam int MASK_SIZE  = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MASK_SIZE-1:0]  req_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int IDX_W  = $clog2(DEPTH);
    // WAIT spends (LATENCY-2)+1 edges counting down, plus the accept edge.
    localparam logic [LAT_W-1:0] CNT_LOAD = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;

    dmem_state_t      state_q, state_d;
    logic [LAT_W-1:0] cnt_q,   cnt_d;
    logic             we_q,    we_d;
    logic             err_q,   err_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic [WORD_W-1:0]     req_word;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_err;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic                  addr_lsb_unused;

    // Byte offset within the word plays no part in indexing.
    assign addr_lsb_unused = ^req_addr[1:0];

    assign req_word = req_addr[ADDR_WIDTH-1:2];
    assign req_idx  = req_word[IDX_W-1:0];
    assign req_err  = (req_word >= WORD_W'(DEPTH));

    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;

    // Out-of-range stores must not alias onto a truncated in-range index.
    assign wr_en = accept && req_we && !req_err;

    // The read is issued on the edge that enters RESP: the accepting edge
    // itself when LATENCY==1, else the last WAIT edge using the latched index.
    // A store can never be accepted on that edge, so no read/write collision.
    assign rd_en  = (accept && (LATENCY == 1) && !req_we && !req_err)
                 || ((state_q == WAIT) && (cnt_q == '0) && !we_q && !err_q);
    assign rd_idx = (state_q == WAIT) ? idx_q : req_idx;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new accept (from IDLE, or from RESP while the response is being
        // consumed) overrides the transitions above.
        if (accept) begin
            we_d  = req_we;
            err_d = req_err;
            idx_d = req_idx;
            if (LATENCY == 1) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    dmem_sram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (wr_en),
        .widx  (req_idx),
        .wdata (req_wdata),
        .be    (req_mask),
        .re    (rd_en),
        .ridx  (rd_idx),
        .rdata (bank_rdata)
    );

    // Response fields are gated by state, so they read 0 out of RESP and clear
    // with the asynchronous reset; the bank register holds data while stalled.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? bank_rdata : '0;

endmodule : dmem_resp

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Directed bench for dmem_resp. Instance u_dut_a runs with LATENCY=1, instance
// u_dut_b with LATENCY=4 (held in reset until its section). Inputs are driven
// and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_resp;

    logic        clk;
    logic        arst_n_a;
    logic        arst_n_b;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] vals [4];

    dmem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(1)) u_dut_a (
        .clk       (clk),
        .arst_n    (arst_n_a),
        .req_valid (req_valid),
        .req_ready (req_ready_a),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a)
    );

    dmem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024), .LATENCY(4)) u_dut_b (
        .clk       (clk),
        .arst_n    (arst_n_b),
        .req_valid (req_valid),
        .req_ready (req_ready_b),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
    endtask

    // One LATENCY=1 transaction with rsp_ready high; starts and ends on a negedge.
    task automatic txn_a(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] exp_rdata, input logic exp_err);
        drive_req(we, addr, wdata, mask);
        rsp_ready = 1'b1;
        #1 check({tag, ".ready"}, 32'(req_ready_a), 32'd1);
        @(posedge clk); @(negedge clk);
        check({tag, ".valid"}, 32'(rsp_valid_a), 32'd1);
        check({tag, ".rdata"}, rsp_rdata_a, exp_rdata);
        check({tag, ".err"},   32'(rsp_err_a), 32'(exp_err));
        idle_req();
        @(posedge clk); @(negedge clk);
        check({tag, ".done"}, 32'(rsp_valid_a), 32'd0);
    endtask

    // One LATENCY=4 transaction: valid must be low for 3 falling edges after
    // accept and high on the 4th.
    task automatic txn_b(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] exp_rdata, input logic exp_err);
        drive_req(we, addr, wdata, mask);
        rsp_ready = 1'b1;
        #1 check({tag, ".ready"}, 32'(req_ready_b), 32'd1);
        @(posedge clk); @(negedge clk);
        idle_req();
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk); @(negedge clk);
            end
            if (k < 4) begin
                check($sformatf("%s.early%0d", tag, k), 32'(rsp_valid_b), 32'd0);
            end else begin
                check({tag, ".valid"}, 32'(rsp_valid_b), 32'd1);
                check({tag, ".rdata"}, rsp_rdata_b, exp_rdata);
                check({tag, ".err"},   32'(rsp_err_b), 32'(exp_err));
            end
            if (k == 1) check({tag, ".wait_ready"}, 32'(req_ready_b), 32'd0);
        end
        @(posedge clk); @(negedge clk);
        check({tag, ".done"}, 32'(rsp_valid_b), 32'd0);
    endtask

    initial begin
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'h3333_3333;
        vals[3] = 32'h4444_4444;

        arst_n_a  = 1'b0;
        arst_n_b  = 1'b0;
        rsp_ready = 1'b1;
        idle_req();
        repeat (3) @(negedge clk);

        // 1: reset state, basic store/load
        arst_n_a = 1'b1;
        #1;
        check("rst.valid", 32'(rsp_valid_a), 32'd0);
        check("rst.ready", 32'(req_ready_a), 32'd1);
        check("rst.rdata", rsp_rdata_a, 32'd0);
        check("rst.err",   32'(rsp_err_a), 32'd0);
        @(negedge clk);
        txn_a("t1.st0",  1'b1, 32'h0000_0000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
        txn_a("t1.st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        txn_a("t1.ld10", 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);

        // 2: byte and half-word stores
        txn_a("t2.stb",  1'b1, 32'h0000_0013, 32'hAA00_0000, 4'b1000, 32'h0, 1'b0);
        txn_a("t2.ldb",  1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hAAAD_BEEF, 1'b0);
        txn_a("t2.sth",  1'b1, 32'h0000_0012, 32'h1234_0000, 4'b1100, 32'h0, 1'b0);
        txn_a("t2.ldh",  1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1234_BEEF, 1'b0);
        txn_a("t2.st0m", 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        txn_a("t2.ld0m", 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h1234_BEEF, 1'b0);

        // 3: response backpressure with a second request pending
        drive_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000);
        rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        drive_req(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3.valid%0d", i), 32'(rsp_valid_a), 32'd1);
            check($sformatf("t3.rdata%0d", i), rsp_rdata_a, 32'h1234_BEEF);
            check($sformatf("t3.ready%0d", i), 32'(req_ready_a), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        check("t3.held", rsp_rdata_a, 32'h1234_BEEF);
        rsp_ready = 1'b1;
        #1 check("t3.release_ready", 32'(req_ready_a), 32'd1);
        @(posedge clk); @(negedge clk);
        check("t3.st_valid", 32'(rsp_valid_a), 32'd1);
        check("t3.st_rdata", rsp_rdata_a, 32'h0);
        idle_req();
        @(posedge clk); @(negedge clk);
        check("t3.idle", 32'(rsp_valid_a), 32'd0);
        txn_a("t3.ld20", 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);

        // 4: back-to-back alternating store/load, one per cycle
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check($sformatf("t4.valid%0d", i - 1), 32'(rsp_valid_a), 32'd1);
                check($sformatf("t4.rdata%0d", i - 1), rsp_rdata_a,
                      ((i - 1) % 2 == 0) ? 32'h0 : vals[(i - 1) / 2]);
            end
            if (i % 2 == 0) drive_req(1'b1, 32'h0000_0020, vals[i / 2], 4'b1111);
            else            drive_req(1'b0, 32'h0000_0020, 32'h0, 4'b0000);
            #1 check($sformatf("t4.ready%0d", i), 32'(req_ready_a), 32'd1);
            @(posedge clk); @(negedge clk);
        end
        check("t4.valid7", 32'(rsp_valid_a), 32'd1);
        check("t4.rdata7", rsp_rdata_a, vals[3]);
        idle_req();
        @(posedge clk); @(negedge clk);
        check("t4.idle", 32'(rsp_valid_a), 32'd0);

        // 5: out-of-range accesses (index 1024 would alias word 0 if truncated)
        txn_a("t5.ld_oor", 1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'h0, 1'b1);
        txn_a("t5.st_oor", 1'b1, 32'h0000_1000, 32'h5555_5555, 4'b1111, 32'h0, 1'b1);
        txn_a("t5.ld0",    1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h1234_5678, 1'b0);

        // 6: LATENCY=4 timing and reset mid-transaction
        arst_n_b = 1'b1;
        #1;
        check("t6.rst_valid", 32'(rsp_valid_b), 32'd0);
        check("t6.rst_ready", 32'(req_ready_b), 32'd1);
        check("t6.rst_rdata", rsp_rdata_b, 32'h0);
        @(negedge clk);
        txn_b("t6.st40", 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);
        txn_b("t6.ld40", 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0);

        drive_req(1'b0, 32'h0000_0040, 32'h0, 4'b0000);
        @(posedge clk); @(negedge clk);
        idle_req();
        @(posedge clk); @(negedge clk);
        arst_n_b = 1'b0;
        #1 check("t6.in_rst_valid", 32'(rsp_valid_b), 32'd0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
        end
        arst_n_b = 1'b1;
        #1;
        check("t6.rel_ready", 32'(req_ready_b), 32'd1);
        check("t6.rel_valid", 32'(rsp_valid_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("t6.dropped%0d", i), 32'(rsp_valid_b), 32'd0);
        end
        txn_b("t6.ld_after", 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_resp
